vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-rate raster timing generator for 640x480@60 VGA. Produces the DrawX/DrawY
//  scan coordinates and active-video flag consumed by color_mapper, plus hs/vs sync.
//  Sync outputs are delayed by PIPE_DELAY clocks so they line up with RGB from the
//  downstream ROM+register stages. Also emits frame and line strobes for game logic.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  PIPE_DELAY 2    clocks of delay on hs/vs/de outputs (0..7; 0 = no delay)
// PORTS
//  vga_clk     in   1   pixel clock; all logic on rising edge
//  Reset       in   1   asynchronous, active-high reset
//  DrawX       out  10  current horizontal count (0..H_TOTAL-1)
//  DrawY       out  10  current vertical count (0..V_TOTAL-1)
//  blank       out  1   1 = (DrawX,DrawY) in visible area; undelayed, for color_mapper
//  hs          out  1   horizontal sync, active-low, delayed PIPE_DELAY clocks
//  vs          out  1   vertical sync, active-low, delayed PIPE_DELAY clocks
//  de          out  1   delayed copy of blank, aligned with hs/vs
//  line_start  out  1   1-clock pulse when DrawX==0
//  frame_start out  1   1-clock pulse when DrawX==0 && DrawY==0
//  frame_tick  out  1   1-clock pulse when DrawX==0 && DrawY==V_ACTIVE+V_FP (vsync start)
//  frame_count out  8   frames completed, increments with frame_start, wraps 255->0
// BEHAVIOUR
//  - H_TOTAL = sum of H_*, V_TOTAL = sum of V_* (800 / 525 default); both must be <= 1024.
//  - Counters hc,vc are registers; DrawX=hc, DrawY=vc. Each clock: hc==H_TOTAL-1 -> hc=0
//    and vc advances (vc==V_TOTAL-1 -> 0); else hc+1. No stall or enable input.
//  - Reset (async): hc=H_TOTAL-1, vc=V_TOTAL-1 (last pixel of prior frame), frame_count=0,
//    all delay-pipe stages = inactive (hs=1, vs=1, de=0). Hence during reset: blank=0,
//    hs=1, vs=1, de=0, line_start=0, frame_start=0, frame_tick=0, DrawX=799, DrawY=524.
//  - First clock after Reset deasserts: DrawX=0, DrawY=0, blank=1, line_start=1,
//    frame_start=1; frame_count stays 0 (increment occurs on the wrap into the next frame's
//    frame_start only after one full frame, i.e. frame_count++ when leaving (H_TOTAL-1,
//    V_TOTAL-1) except the first exit after reset).
//  - blank = (hc < H_ACTIVE) && (vc < V_ACTIVE), decoded from registers (no glitch path).
//  - Raw hs low iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - Raw vs low iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491), whole lines.
//  - hs/vs/de = raw hs/vs/blank passed through PIPE_DELAY-stage shift register;
//    PIPE_DELAY=0 drives them directly from the decode. Strobes are undelayed.
//  - Reset mid-frame: counters and pipe return to reset values immediately (async);
//    no partial sync pulse may extend past Reset assertion on hs/vs.
// TESTING
//  1 Reset then release -> cycle 1: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
//  2 Free-run one line -> line_start period 800 clks; blank high exactly 640 clks per line.
//  3 PIPE_DELAY=2 -> hs falls 2 clks after DrawX==656, stays low 96 clks, period 800.
//  4 Full frame -> vs low 1600 clks starting at DrawY==490 (+2 clk delay); frame 420000 clks;
//    frame_tick once per frame at (0,490); frame_count 0->1 at second frame_start.
//  5 Run 256 frames -> frame_count wraps 255->0; blank never high for DrawY>=480.
//  6 Assert Reset at (300,200) mid-line -> same cycle hs=1, vs=1, de=0, blank=0,
//    DrawX=799, DrawY=524; after release sequence identical to scenario 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters, visible-area flag, pixel-aligned hs/vs/de
// through a configurable delay pipe, and line/frame strobes plus a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       line_start,
  output logic       frame_start,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FCW     = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_MAX     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]  hc_q, hc_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           first_q, first_d;
  logic           blank_q, blank_d;
  logic           hs_raw_q, hs_raw_d;
  logic           vs_raw_q, vs_raw_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic           ft_q, ft_d;
  logic           h_wrap;
  logic           f_wrap;

  // Next-state counters; all decodes are taken from the next counter values so that
  // the registered flags line up with the registered DrawX/DrawY.
  always_comb begin
    h_wrap   = (hc_q == H_MAX);
    f_wrap   = h_wrap && (vc_q == V_MAX);
    hc_d     = h_wrap ? '0 : hc_q + CW'(1);
    vc_d     = vc_q;
    fcnt_d   = fcnt_q;
    first_d  = first_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_MAX) ? '0 : vc_q + CW'(1);
    end
    // The first wrap after reset only starts frame 0; later wraps complete a frame.
    if (f_wrap) begin
      if (!first_q) begin
        fcnt_d = fcnt_q + FCW'(1);
      end
      first_d = 1'b0;
    end
    blank_d  = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_raw_d = !((hc_d >= H_SYNC_S) && (hc_d < H_SYNC_E));
    vs_raw_d = !((vc_d >= V_SYNC_S) && (vc_d < V_SYNC_E));
    ls_d     = (hc_d == '0);
    fs_d     = (hc_d == '0) && (vc_d == '0);
    ft_d     = (hc_d == '0) && (vc_d == V_SYNC_S);
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc_q     <= H_MAX;
      vc_q     <= V_MAX;
      fcnt_q   <= '0;
      first_q  <= 1'b1;
      blank_q  <= 1'b0;
      hs_raw_q <= 1'b1;
      vs_raw_q <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      ft_q     <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      fcnt_q   <= fcnt_d;
      first_q  <= first_d;
      blank_q  <= blank_d;
      hs_raw_q <= hs_raw_d;
      vs_raw_q <= vs_raw_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      ft_q     <= ft_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_tick  = ft_q;
  assign frame_count = fcnt_q;

  // Sync/enable delay pipe; reset loads the inactive levels so no pulse survives reset.
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign hs = hs_raw_q;
    assign vs = vs_raw_q;
    assign de = blank_q;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_pipe_q;
    logic [PIPE_DELAY-1:0] vs_pipe_q;
    logic [PIPE_DELAY-1:0] de_pipe_q;

    always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        de_pipe_q <= '0;
      end else begin
        hs_pipe_q[0] <= hs_raw_q;
        vs_pipe_q[0] <= vs_raw_q;
        de_pipe_q[0] <= blank_q;
        for (int i = 1; i < int'(PIPE_DELAY); i++) begin
          hs_pipe_q[i] <= hs_pipe_q[i-1];
          vs_pipe_q[i] <= vs_pipe_q[i-1];
          de_pipe_q[i] <= de_pipe_q[i-1];
        end
      end
    end

    assign hs = hs_pipe_q[PIPE_DELAY-1];
    assign vs = vs_pipe_q[PIPE_DELAY-1];
    assign de = de_pipe_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster so wrap of frame_count fits
// in a short run; expected outputs come from a time-indexed raster model.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       vga_clk = 1'b0;
  logic       Reset   = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, de, line_start, frame_start, frame_tick;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .hs(hs), .vs(vs), .de(de),
    .line_start(line_start), .frame_start(frame_start), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  logic [34:0] obs;
  assign obs = {DrawX, DrawY, blank, hs, vs, de, line_start, frame_start, frame_tick, frame_count};

  localparam logic [34:0] RST_V = {10'(HT-1), 10'(VT-1), 1'b0, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 8'd0};

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] sb_q[$];

  int hs_run, ls_last, bad_blank, ticks;
  logic saw_wrap;
  logic [7:0] fc_prev;

  // Expected outputs t cycles after reset release (t=0 is the first pixel of frame 0).
  function automatic logic [34:0] exp_at(input int t);
    int x, y, fc, td, xd, yd;
    logic bl, hsd, vsd, ded;
    x  = t % HT;
    y  = (t / HT) % VT;
    fc = (t / FT) % 256;
    bl = (x < HA) && (y < VA);
    td = t - PD;
    if (td < 0) begin
      hsd = 1'b1; vsd = 1'b1; ded = 1'b0;
    end else begin
      xd  = td % HT;
      yd  = (td / HT) % VT;
      hsd = !((xd >= HA + HF) && (xd < HA + HF + HS));
      vsd = !((yd >= VA + VF) && (yd < VA + VF + VS));
      ded = (xd < HA) && (yd < VA);
    end
    return {10'(x), 10'(y), bl, hsd, vsd, ded, (x == 0), (x == 0 && y == 0),
            (x == 0 && y == VA + VF), 8'(fc)};
  endfunction

  task automatic chk(input string tag, input logic [34:0] o, input logic [34:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic clear_stats();
    hs_run = 0; ls_last = -1; bad_blank = 0; ticks = 0; saw_wrap = 1'b0; fc_prev = 8'd0;
  endtask

  // One clock: push model value at the edge, pop and compare at the following negedge.
  task automatic step(input int t);
    @(posedge vga_clk);
    sb_q.push_back(exp_at(t));
    @(negedge vga_clk);
    chk("raster", obs, sb_q.pop_front());
    if (blank && (int'(DrawY) >= VA)) bad_blank++;
    if (frame_tick) ticks++;
    if (fc_prev == 8'd255 && frame_count == 8'd0) saw_wrap = 1'b1;
    fc_prev = frame_count;
    if (line_start) begin
      if (ls_last >= 0) chk_int("line_period", t - ls_last, HT);
      ls_last = t;
    end
    if (!hs) hs_run++;
    else begin
      if (hs_run != 0) chk_int("hs_width", hs_run, HS);
      hs_run = 0;
    end
  endtask

  initial begin
    int t;
    logic found;
    clear_stats();

    // Reset held: inactive outputs, counters parked on the last pixel.
    repeat (3) begin
      @(negedge vga_clk);
      chk("reset", obs, RST_V);
    end
    Reset = 1'b0;

    // Free-run past 256 frames so frame_count wraps.
    t = 0;
    for (int i = 0; i < 257 * FT + 1; i++) begin
      step(t);
      t++;
    end
    chk_int("bottom_blank", bad_blank, 0);
    chk_int("frame_ticks", ticks, 257);
    chk_int("fc_wrap", int'(saw_wrap), 1);

    // Advance to a pixel where delayed hs and vs are both low, then reset mid-pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step(t);
      t++;
      if (DrawX == 10'd13 && DrawY == 10'd5) found = 1'b1;
    end
    chk_int("find_sync", int'(found), 1);
    chk_int("pre_rst_hs", int'(hs), 0);
    chk_int("pre_rst_vs", int'(vs), 0);
    #2 Reset = 1'b1;
    #1 chk("mid_reset", obs, RST_V);
    @(negedge vga_clk);
    chk("mid_reset_hold", obs, RST_V);
    Reset = 1'b0;
    clear_stats();

    for (int i = 0; i < 2 * FT; i++) step(i);
    chk_int("post_ticks", ticks, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
